axis_master: RTL

AXIS_MASTER -- requirements
Module: axis_master

---
 rtl/axis_master.sv | 96 +++++++++
 1 files changed

// File: rtl/axis_master.sv
// AXI4-Stream master fed by a show-ahead FIFO of MLP result words.
// Beats are grouped into frames of FRAME_LEN; TLAST marks the final beat of each frame.
module axis_master #(
  parameter int C_M_AXIS_TDATA_WIDTH = 32,
  parameter int FIFO_DEPTH           = 16,
  parameter int FRAME_LEN            = 10
) (
  input  logic                              M_AXIS_ACLK,
  input  logic                              M_AXIS_ARESETN,
  input  logic                              pi_mlp_data_valid,
  input  logic [C_M_AXIS_TDATA_WIDTH-1:0]   pi_mlp_data,
  output logic                              po_mlp_data_ready,
  output logic                              po_frame_done,
  output logic                              M_AXIS_TVALID,
  output logic [C_M_AXIS_TDATA_WIDTH-1:0]   M_AXIS_TDATA,
  output logic [C_M_AXIS_TDATA_WIDTH/8-1:0] M_AXIS_TSTRB,
  output logic                              M_AXIS_TLAST,
  input  logic                              M_AXIS_TREADY
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int BEAT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

  localparam logic [PTR_W:0]    DEPTH_C   = (PTR_W+1)'(FIFO_DEPTH);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(FRAME_LEN - 1);

  logic [C_M_AXIS_TDATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]    count_q,  count_d;
  logic [BEAT_W-1:0] beat_q,   beat_d;
  logic              frame_done_q, frame_done_d;

  logic full, empty, push, pop;

  // Ready and valid come only from the occupancy count, so TVALID never
  // sees TREADY combinationally and a full FIFO refuses a push even while popping.
  assign full  = (count_q == DEPTH_C);
  assign empty = (count_q == '0);
  assign push  = pi_mlp_data_valid && !full;
  assign pop   = !empty && M_AXIS_TREADY;

  assign po_mlp_data_ready = !full;
  assign M_AXIS_TVALID     = !empty;
  assign M_AXIS_TDATA      = mem_q[rd_ptr_q];
  assign M_AXIS_TSTRB      = '1;
  assign M_AXIS_TLAST      = !empty && (beat_q == LAST_BEAT);
  assign po_frame_done     = frame_done_q;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (which would infer a latch).
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    beat_d       = beat_q;
    frame_done_d = 1'b0;

    if (push) wr_ptr_d = wr_ptr_q + 1'b1;

    if (pop) begin
      rd_ptr_d     = rd_ptr_q + 1'b1;
      frame_done_d = (beat_q == LAST_BEAT);
      beat_d       = (beat_q == LAST_BEAT) ? '0 : beat_q + 1'b1;
    end

    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
    if (!M_AXIS_ARESETN) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      beat_q       <= '0;
      frame_done_q <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      beat_q       <= beat_d;
      frame_done_q <= frame_done_d;
    end
  end

  // NOTE: storage is deliberately left out of reset; the cleared count makes stale entries invisible.
  always_ff @(posedge M_AXIS_ACLK) begin
    if (push) mem_q[wr_ptr_q] <= pi_mlp_data;
  end

endmodule
